// File: rtl/ls_mem_ctrl_if.sv
// LS function encoding and the bundled upstream / memory / writeback signals
// seen by the load/store memory sequencer.
package ls_mem_pkg;
  typedef enum logic [3:0] {
    LS_NOP = 4'd0,
    LS_LB  = 4'd1,
    LS_LH  = 4'd2,
    LS_LW  = 4'd3,
    LS_LBU = 4'd4,
    LS_LHU = 4'd5,
    LS_SB  = 4'd6,
    LS_SH  = 4'd7,
    LS_SW  = 4'd8
  } ls_func_e;
endpackage

interface ls_mem_if #(
  parameter int RD_W = 7
);
  logic                  valid_i;
  logic                  ready_i;
  ls_mem_pkg::ls_func_e  ls_func_i;
  logic [31:0]           addr_i;
  logic [31:0]           data_i;
  logic [RD_W-1:0]       rd_i;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [31:0]           mem_addr_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;
  logic                  wb_valid_o;
  logic [RD_W-1:0]       wb_rd_o;
  logic [31:0]           wb_data_o;
  logic                  wb_ready_i;
  logic                  err_o;
  logic [31:0]           err_addr_o;
  logic                  idle_o;

  // master: the sequencer; slave: the surrounding pipeline, memory and writeback
  modport master (
    input  valid_i, ls_func_i, addr_i, data_i, rd_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, wb_ready_i,
    output ready_i, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output wb_valid_o, wb_rd_o, wb_data_o, err_o, err_addr_o, idle_o
  );

  modport slave (
    output valid_i, ls_func_i, addr_i, data_i, rd_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, wb_ready_i,
    input  ready_i, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, err_o, err_addr_o, idle_o
  );
endinterface

// File: rtl/ls_mem_ctrl.sv
// Load/store sequencer: buffers LS ops in a FIFO and issues them one at a time,
// in order, to a single-ported data memory; aligns loads and lane-places stores.
module ls_mem_ctrl
  import ls_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RD_W  = 7
) (
  input  logic     clk,
  input  logic     reset,
  ls_mem_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_WB,
    S_ERR
  } state_e;

  function automatic logic is_store(ls_func_e f);
    return (f == LS_SB) || (f == LS_SH) || (f == LS_SW);
  endfunction

  function automatic logic misaligned(ls_func_e f, logic [1:0] off);
    case (f)
      LS_LH, LS_LHU, LS_SH: return off[0];
      LS_LW, LS_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(ls_func_e f, logic [1:0] off);
    case (f)
      LS_SB:   return 4'b0001 << off;
      LS_SH:   return 4'b0011 << off;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(ls_func_e f, logic [31:0] d);
    case (f)
      LS_SB:   return {4{d[7:0]}};
      LS_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(ls_func_e f, logic [1:0] off, logic [31:0] word);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (f)
      LS_LB:   return {{24{s[7]}}, s[7:0]};
      LS_LBU:  return {24'd0, s[7:0]};
      LS_LH:   return {{16{s[15]}}, s[15:0]};
      LS_LHU:  return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  ls_func_e        r_fifo_func [DEPTH];
  logic [31:0]     r_fifo_addr [DEPTH];
  logic [31:0]     r_fifo_data [DEPTH];
  logic [RD_W-1:0] r_fifo_rd   [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;

  state_e          r_state;
  state_e          w_next;
  ls_func_e        r_op_func;
  logic [31:0]     r_op_addr;
  logic [31:0]     r_op_data;
  logic [RD_W-1:0] r_op_rd;
  logic [31:0]     r_wb_data;
  logic [31:0]     r_err_addr;

  logic            w_empty;
  logic            w_full;
  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  ls_func_e        w_head_func;
  logic [31:0]     w_head_addr;
  logic            w_head_mis;
  logic            w_req;
  logic            w_wb_vld;
  logic            w_err;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_ready     = !w_full && !reset;
  assign w_push      = bus.valid_i && w_ready && (bus.ls_func_i != LS_NOP);
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head_func = r_fifo_func[r_rptr[AW-1:0]];
  assign w_head_addr = r_fifo_addr[r_rptr[AW-1:0]];
  assign w_head_mis  = misaligned(w_head_func, w_head_addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_state    <= S_IDLE;
      r_err_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_pop && w_head_mis) r_err_addr <= w_head_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_func[r_wptr[AW-1:0]] <= bus.ls_func_i;
      r_fifo_addr[r_wptr[AW-1:0]] <= bus.addr_i;
      r_fifo_data[r_wptr[AW-1:0]] <= bus.data_i;
      r_fifo_rd[r_wptr[AW-1:0]]   <= bus.rd_i;
    end
    if (w_pop) begin
      r_op_func <= w_head_func;
      r_op_addr <= w_head_addr;
      r_op_data <= r_fifo_data[r_rptr[AW-1:0]];
      r_op_rd   <= r_fifo_rd[r_rptr[AW-1:0]];
    end
    if ((r_state == S_WAIT_R) && bus.mem_rvalid_i)
      r_wb_data <= load_extend(r_op_func, r_op_addr[1:0], bus.mem_rdata_i);
  end

  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_wb_vld = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE:   if (!w_empty) w_next = w_head_mis ? S_ERR : S_REQ;
      S_REQ: begin
        w_req = 1'b1;
        if (bus.mem_gnt_i) w_next = is_store(r_op_func) ? S_IDLE : S_WAIT_R;
      end
      S_WAIT_R: if (bus.mem_rvalid_i) w_next = S_WB;
      S_WB: begin
        w_wb_vld = 1'b1;
        if (bus.wb_ready_i) w_next = S_IDLE;
      end
      S_ERR: begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath outputs are forced to zero outside their valid state.
  assign bus.ready_i     = w_ready;
  assign bus.mem_req_o   = w_req;
  assign bus.mem_we_o    = w_req && is_store(r_op_func);
  assign bus.mem_addr_o  = w_req ? {r_op_addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_be_o    = w_req ? lane_be(r_op_func, r_op_addr[1:0]) : 4'd0;
  assign bus.mem_wdata_o = w_req ? lane_wdata(r_op_func, r_op_data) : 32'd0;
  assign bus.wb_valid_o  = w_wb_vld;
  assign bus.wb_rd_o     = w_wb_vld ? r_op_rd : '0;
  assign bus.wb_data_o   = w_wb_vld ? r_wb_data : 32'd0;
  assign bus.err_o       = w_err;
  assign bus.err_addr_o  = r_err_addr;
  assign bus.idle_o      = (r_state == S_IDLE) && w_empty;

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Bench for ls_mem_ctrl: queue-based reference model checked every cycle, a
// randomized memory/writeback responder, directed cases and a random phase.
module tb_ls_mem_ctrl;
  import ls_mem_pkg::*;

  localparam int DEPTH = 4;
  localparam int RD_W  = 7;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ls_mem_if #(.RD_W(RD_W)) bus ();

  ls_mem_ctrl #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic bit mis(ls_func_e f, logic [31:0] a);
    if (f inside {LS_LH, LS_LHU, LS_SH}) return a[0];
    if (f inside {LS_LW, LS_SW})         return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic bit st(ls_func_e f);
    return f inside {LS_SB, LS_SH, LS_SW};
  endfunction

  function automatic logic [3:0] exp_be(ls_func_e f, logic [31:0] a);
    if (f == LS_SB) return 4'(1 << a[1:0]);
    if (f == LS_SH) return (a[1] ? 4'b1100 : 4'b0011);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(ls_func_e f, logic [31:0] d);
    if (f == LS_SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f == LS_SH) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] ld_ext(ls_func_e f, logic [31:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int o;
    o = int'(a[1:0]);
    b = w[8*o +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      LS_LB:   return 32'($signed(b));
      LS_LBU:  return {24'd0, b};
      LS_LH:   return 32'($signed(h));
      LS_LHU:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- responder knobs ----------------
  bit          rand_mode    = 0;
  bit          spur_en      = 0;
  bit          fix_rdata_en = 1;
  logic [31:0] fix_rdata    = 32'd0;
  int          fix_gnt      = 0;
  int          fix_rv       = 0;
  int          fix_wb       = 0;

  function automatic int pick(int fixed_v);
    return rand_mode ? int'($urandom_range(0, 3)) : fixed_v;
  endfunction

  int req_wait = 0, rv_wait = 0, wb_wait = 0;
  int gnt_lat = 0, rv_lat = 0, wb_lat = 0;
  bit rd_pend = 0;

  initial begin
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'd0;
    bus.wb_ready_i   = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.wb_ready_i   = 1'b0;
    bus.mem_rdata_i  = fix_rdata_en ? fix_rdata : $urandom();
    if (reset) begin
      rd_pend = 0; req_wait = 0; rv_wait = 0; wb_wait = 0;
    end else begin
      if (rd_pend) begin
        if (rv_wait >= rv_lat) begin
          bus.mem_rvalid_i = 1'b1;
          rd_pend = 0;
        end else rv_wait++;
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        bus.mem_rvalid_i = 1'b1;
      end
      if (bus.mem_req_o) begin
        if (req_wait == 0) gnt_lat = pick(fix_gnt);
        if (req_wait >= gnt_lat) begin
          bus.mem_gnt_i = 1'b1;
          req_wait = 0;
          if (!bus.mem_we_o) begin
            rd_pend = 1; rv_wait = 0; rv_lat = pick(fix_rv);
          end
        end else req_wait++;
      end
      if (bus.wb_valid_o) begin
        if (wb_wait == 0) wb_lat = pick(fix_wb);
        if (wb_wait >= wb_lat) begin
          bus.wb_ready_i = 1'b1;
          wb_wait = 0;
        end else wb_wait++;
      end
    end
  end

  // ---------------- model + per-cycle compare ----------------
  typedef struct {
    ls_func_e        f;
    logic [31:0]     a;
    logic [31:0]     d;
    logic [RD_W-1:0] rd;
    bit              granted;
    bit              have;
    logic [31:0]     wbx;
  } op_t;

  op_t q[$];
  op_t n;
  int  n_req = 0, n_err = 0, n_wb = 0;
  int  push_cyc = 0, req_start = 0, wb_start = 0;
  bit  prev_req = 0, prev_wb = 0, saw_full = 0;
  logic [31:0] o_addr, o_be, o_wd, o_we, o_wb_data, o_wb_rd, o_err_addr;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      prev_req = 0;
      prev_wb  = 0;
    end else begin
      chk("idle", 32'(bus.idle_o), 32'(q.size() == 0));
      if (!bus.ready_i) saw_full = 1;
      if (bus.mem_rvalid_i && q.size() > 0 && q[0].granted && !q[0].have) begin
        q[0].wbx  = ld_ext(q[0].f, q[0].a, bus.mem_rdata_i);
        q[0].have = 1;
      end
      if (bus.mem_req_o) begin
        if (!prev_req) req_start = cyc;
        if (q.size() == 0 || mis(q[0].f, q[0].a) || q[0].granted) begin
          chk("req_unexpected", 32'(bus.mem_req_o), 32'd0);
        end else begin
          chk("mem_addr", bus.mem_addr_o, {q[0].a[31:2], 2'b00});
          chk("mem_we", 32'(bus.mem_we_o), 32'(st(q[0].f)));
          chk("mem_be", 32'(bus.mem_be_o), 32'(exp_be(q[0].f, q[0].a)));
          if (st(q[0].f)) chk("mem_wdata", bus.mem_wdata_o, exp_wd(q[0].f, q[0].d));
          if (bus.mem_gnt_i) begin
            n_req++;
            o_addr = bus.mem_addr_o; o_be = 32'(bus.mem_be_o);
            o_wd   = bus.mem_wdata_o; o_we = 32'(bus.mem_we_o);
            if (st(q[0].f)) void'(q.pop_front());
            else q[0].granted = 1;
          end
        end
      end
      prev_req = bus.mem_req_o;
      if (bus.err_o) begin
        if (q.size() == 0 || !mis(q[0].f, q[0].a)) begin
          chk("err_unexpected", 32'(bus.err_o), 32'd0);
        end else begin
          chk("err_addr", bus.err_addr_o, q[0].a);
          o_err_addr = bus.err_addr_o;
          n_err++;
          void'(q.pop_front());
        end
      end
      if (bus.wb_valid_o) begin
        if (!prev_wb) wb_start = cyc;
        if (q.size() == 0 || !q[0].have) begin
          chk("wb_unexpected", 32'(bus.wb_valid_o), 32'd0);
        end else begin
          chk("wb_rd", 32'(bus.wb_rd_o), 32'(q[0].rd));
          chk("wb_data", bus.wb_data_o, q[0].wbx);
          if (bus.wb_ready_i) begin
            n_wb++;
            o_wb_data = bus.wb_data_o;
            o_wb_rd   = 32'(bus.wb_rd_o);
            void'(q.pop_front());
          end
        end
      end
      prev_wb = bus.wb_valid_o;
      if (bus.valid_i && bus.ready_i && bus.ls_func_i != LS_NOP) begin
        n.f = bus.ls_func_i; n.a = bus.addr_i; n.d = bus.data_i; n.rd = bus.rd_i;
        n.granted = 0; n.have = 0; n.wbx = 32'd0;
        q.push_back(n);
        push_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(ls_func_e f, logic [31:0] a, logic [31:0] d, logic [RD_W-1:0] r);
    int t;
    bit acc;
    t = 0;
    bus.valid_i = 1'b1; bus.ls_func_i = f; bus.addr_i = a; bus.data_i = d; bus.rd_i = r;
    forever begin
      @(negedge clk);
      acc = bus.ready_i;
      @(posedge clk);
      if (acc) break;
      t++;
      if (t > 300) begin
        chk("send_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    #1 bus.valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.idle_o && q.size() == 0) && t < 1000);
    chk("drain", 32'(bus.idle_o && q.size() == 0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic knobs(int g, int r, int w);
    fix_gnt = g; fix_rv = r; fix_wb = w;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          k, e0, w0, r0;
  ls_func_e    rf;
  logic [31:0] ra;

  initial begin
    bus.valid_i = 1'b0; bus.ls_func_i = LS_NOP; bus.addr_i = 32'd0;
    bus.data_i  = 32'd0; bus.rd_i = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", 32'(bus.ready_i), 32'd0);
    chk("rst_idle", 32'(bus.idle_o), 32'd1);
    chk("rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_err_addr", bus.err_addr_o, 32'd0);
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("rel_ready", 32'(bus.ready_i), 32'd1);
    @(posedge clk); #1;

    // store word, immediate grant
    knobs(0, 0, 0);
    send(LS_SW, 32'h100, 32'hDEADBEEF, '0);
    drain();
    chk("sw_we", o_we, 32'd1);
    chk("sw_addr", o_addr, 32'h100);
    chk("sw_be", o_be, 32'hF);
    chk("sw_wdata", o_wd, 32'hDEADBEEF);
    chk("sw_req_lat", 32'(req_start - push_cyc), 32'd2);

    send(LS_SB, 32'h203, 32'h000000A5, '0);
    drain();
    chk("sb_addr", o_addr, 32'h200);
    chk("sb_be", o_be, 32'h8);
    chk("sb_wdata", o_wd, 32'hA5A5A5A5);
    send(LS_SH, 32'h202, 32'h00001234, '0);
    drain();
    chk("sh_be", o_be, 32'hC);
    chk("sh_wdata", o_wd, 32'h12341234);

    // loads with fixed read data
    fix_rdata = 32'h0000_8000;
    send(LS_LB, 32'h301, 32'd0, 7'd5);
    drain();
    chk("lb_rd", o_wb_rd, 32'd5);
    chk("lb_data", o_wb_data, 32'hFFFFFF80);
    chk("ld_req_lat", 32'(req_start - push_cyc), 32'd2);
    chk("ld_wb_lat", 32'(wb_start - push_cyc), 32'd4);
    send(LS_LBU, 32'h301, 32'd0, 7'd5);
    drain();
    chk("lbu_data", o_wb_data, 32'h00000080);
    fix_rdata = 32'h8001_0000;
    send(LS_LH, 32'h302, 32'd0, 7'd6);
    drain();
    chk("lh_data", o_wb_data, 32'hFFFF8001);

    // misaligned word load, then a good one
    e0 = n_err; r0 = n_req;
    send(LS_LW, 32'h402, 32'd0, 7'd9);
    drain();
    chk("mis_err_cnt", 32'(n_err - e0), 32'd1);
    chk("mis_err_addr", o_err_addr, 32'h402);
    chk("mis_no_req", 32'(n_req - r0), 32'd0);
    fix_rdata = 32'hCAFEF00D;
    send(LS_LW, 32'h404, 32'd0, 7'd10);
    drain();
    chk("lw_after_err", o_wb_data, 32'hCAFEF00D);
    chk("lw_after_err_rd", o_wb_rd, 32'd10);

    // backpressure with NOPs interleaved
    knobs(3, 1, 2);
    saw_full = 0; w0 = n_wb; r0 = n_req;
    fix_rdata = 32'h8180_7F01;
    send(LS_LW,  32'h600, 32'd0, 7'd1);
    send(LS_NOP, 32'h777, 32'd0, 7'd0);
    send(LS_SW,  32'h604, 32'h01020304, 7'd0);
    send(LS_LH,  32'h606, 32'd0, 7'd2);
    send(LS_NOP, 32'h779, 32'd0, 7'd0);
    send(LS_LBU, 32'h607, 32'd0, 7'd3);
    send(LS_SB,  32'h608, 32'h000000EE, 7'd0);
    drain();
    chk("bp_saw_full", 32'(saw_full), 32'd1);
    chk("bp_wb_cnt", 32'(n_wb - w0), 32'd3);
    chk("bp_req_cnt", 32'(n_req - r0), 32'd5);
    chk("bp_last_rd", o_wb_rd, 32'd3);
    chk("bp_last_lbu", o_wb_data, 32'h00000081);

    // reset while waiting for read data
    knobs(0, 5, 0);
    send(LS_LW, 32'h700, 32'd0, 7'd11);
    k = 0;
    while (!(q.size() > 0 && q[0].granted) && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("wait_r_reached", 32'(q.size() > 0 && q[0].granted && !q[0].have), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("mid_rst_wb", 32'(bus.wb_valid_o), 32'd0);
    chk("mid_rst_idle", 32'(bus.idle_o), 32'd1);
    chk("mid_rst_ready", 32'(bus.ready_i), 32'd0);
    chk("mid_rst_err_addr", bus.err_addr_o, 32'd0);
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    knobs(0, 0, 0);
    w0 = n_wb;
    fix_rdata = 32'h11223344;
    send(LS_LW, 32'h704, 32'd0, 7'd12);
    drain();
    chk("post_rst_wb", 32'(n_wb - w0), 32'd1);
    chk("post_rst_data", o_wb_data, 32'h11223344);

    // randomized traffic
    rand_mode = 1; spur_en = 1; fix_rdata_en = 0;
    for (int i = 0; i < 300; i++) begin
      rf = ls_func_e'($urandom_range(0, 8));
      ra = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (rf inside {LS_LH, LS_LHU, LS_SH}) ra[0] = 1'b0;
        if (rf inside {LS_LW, LS_SW})         ra[1:0] = 2'b00;
      end
      send(rf, ra, $urandom(), RD_W'($urandom()));
      k = $urandom_range(0, 2);
      repeat (k) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
